// File: rtl/f_pkg.sv
// Shared types and constants for the floating-point running-max tracker.
package f_pkg;

  localparam int unsigned F_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [F_W-1:0] F_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]     F_EXP_MAX = 8'hFF;

  // Map an IEEE-754 single onto an unsigned key whose integer order is the float order.
  // Both zeros collapse to the same key so +0 == -0.
  function automatic logic [F_W-1:0] f_order_key(input logic [F_W-1:0] x);
    logic [F_W-1:0] k;
    if (x[30:0] == 31'd0)  k = 32'h8000_0000;
    else if (x[31])        k = ~x;
    else                   k = x | 32'h8000_0000;
    return k;
  endfunction

endpackage

// File: rtl/f_max_tracker_if.sv
// Handshake/result bundle for f_max_tracker; master drives a scan, slave is the tracker.
interface f_max_tracker_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_max;
  logic [LEN_W-1:0] out_idx;
  logic             out_nan;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_nan, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_nan, busy
  );
endinterface

// File: rtl/f_cmp_gt.sv
// Combinational strict greater-than for IEEE-754 singles, with NaN detection on a.
module f_cmp_gt
  import f_pkg::*;
(
  input  logic [F_W-1:0] a,
  input  logic [F_W-1:0] b,
  output logic           a_gt_b,
  output logic           a_is_nan
);

  logic b_is_nan;

  always_comb begin
    a_is_nan = (a[30:23] == F_EXP_MAX) && (a[22:0] != 23'd0);
    b_is_nan = (b[30:23] == F_EXP_MAX) && (b[22:0] != 23'd0);
    a_gt_b   = !a_is_nan && !b_is_nan && (f_order_key(a) > f_order_key(b));
  end

endmodule

// File: rtl/f_max_tracker.sv
// Scans len IEEE-754 singles from a valid/ready stream and reports the first maximum,
// its index, and whether any NaN was seen.
module f_max_tracker
  import f_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_max,
  output logic [LEN_W-1:0] out_idx,
  output logic             out_nan,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             have_num_q, have_num_d;
  logic [31:0]      max_q, max_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             nan_q, nan_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             in_gt_max;
  logic             in_is_nan;

  f_cmp_gt u_cmp (
    .a        (in_data),
    .b        (max_q),
    .a_gt_b   (in_gt_max),
    .a_is_nan (in_is_nan)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    have_num_d = have_num_q;
    max_d      = max_q;
    idx_d      = idx_q;
    nan_d      = nan_q;

    unique case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          len_d      = len;
          cnt_d      = '0;
          have_num_d = 1'b0;
          nan_d      = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (in_valid) begin
          if (in_is_nan) begin
            nan_d = 1'b1;
          end else if (!have_num_q || in_gt_max) begin
            max_d      = in_data;
            idx_d      = cnt_q;
            have_num_d = 1'b1;
          end
          cnt_d = cnt_q + LEN_W'(1);
          // Last element: publish, substituting a quiet NaN when nothing numeric arrived.
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = DONE;
            if (!have_num_d) begin
              max_d = F_QNAN;
              idx_d = '0;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == SCAN);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      have_num_q  <= 1'b0;
      max_q       <= '0;
      idx_q       <= '0;
      nan_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      have_num_q  <= have_num_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      nan_q       <= nan_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_nan   = nan_q;

endmodule

// File: tb/tb_f_max_tracker.sv
// Directed scoreboard bench for f_max_tracker: stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_f_max_tracker;

  localparam int unsigned LEN_W = 8;

  typedef struct {
    logic [31:0]      mx;
    logic [LEN_W-1:0] idx;
    logic             nan;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  exp_t mon_e;
  logic hs_prev;

  f_max_tracker_if #(.LEN_W(LEN_W)) bus ();

  f_max_tracker #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (bus.start),
    .len       (bus.len),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (bus.in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_max   (bus.out_max),
    .out_idx   (bus.out_idx),
    .out_nan   (bus.out_nan),
    .busy      (bus.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: compare on handshake, then require out_valid low one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
      hs_prev = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got max %h with empty scoreboard", bus.out_max);
        end else begin
          mon_e = sb_q.pop_front();
          chk("out_max", bus.out_max, mon_e.mx);
          chk("out_idx", 32'(bus.out_idx), 32'(mon_e.idx));
          chk("out_nan", 32'(bus.out_nan), 32'(mon_e.nan));
        end
        hs_prev = 1'b1;
      end
    end
  end

  task automatic push(input logic [31:0] mx, input int idx, input logic nan);
    exp_t e;
    e.mx  = mx;
    e.idx = LEN_W'(idx);
    e.nan = nan;
    sb_q.push_back(e);
  endtask

  task automatic start_scan(input int n);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  task automatic send(input logic [31:0] d, input int gaps);
    int waited;
    bus.in_valid = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 50) begin
        chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy || sb_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        chk("idle_timeout", 32'(bus.busy), 32'd0);
        sb_q.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] vec [4];

  task automatic run(input int n, input int rnd_gaps);
    start_scan(n);
    for (int i = 0; i < n; i++) send(vec[i], rnd_gaps ? int'($urandom_range(0, 2)) : 0);
    wait_idle();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    hs_prev       = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_out_max",   bus.out_max,        32'd0);
    chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
    chk("rst_out_nan",   32'(bus.out_nan),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // len=0 start is ignored
    start_scan(0);
    chk("len0_busy",     32'(bus.busy),     32'd0);
    chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("len0_busy_later", 32'(bus.busy), 32'd0);

    // Positive values with a tie: earlier index kept
    vec = '{32'h3F80_0000, 32'hC000_0000, 32'h4060_0000, 32'h4060_0000};
    push(32'h4060_0000, 2, 1'b0);
    start_scan(4);
    chk("start_busy",     32'(bus.busy),     32'd1);
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) send(vec[i], 0);
    wait_idle();

    // All negative: least-magnitude wins
    vec = '{32'hBF80_0000, 32'hBF00_0000, 32'hC080_0000, 32'h0};
    push(32'hBF00_0000, 1, 1'b0);
    run(3, 1);

    // +0 then -0: equal, first kept
    vec = '{32'h0000_0000, 32'h8000_0000, 32'h0, 32'h0};
    push(32'h0000_0000, 0, 1'b0);
    run(2, 0);

    // NaN, -Inf, smallest denormal
    vec = '{32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001, 32'h0};
    push(32'h0000_0001, 2, 1'b1);
    run(3, 1);

    // All NaN: quiet NaN reported at index 0
    vec = '{32'h7FC0_0000, 32'hFFC0_0001, 32'h0, 32'h0};
    push(32'h7FC0_0000, 0, 1'b1);
    run(2, 0);

    // Denormals ordered by value
    vec = '{32'h0000_0002, 32'h0000_0003, 32'h0000_0001, 32'h0};
    push(32'h0000_0003, 1, 1'b0);
    run(3, 1);

    // Backpressure: results held in DONE, start ignored, stray in_valid ignored
    bus.out_ready = 1'b0;
    vec = '{32'hC000_0000, 32'h3F80_0000, 32'h0, 32'h0};
    push(32'h3F80_0000, 1, 1'b0);
    start_scan(2);
    send(vec[0], int'($urandom_range(0, 2)));
    send(vec[1], int'($urandom_range(0, 2)));
    chk("done_latency", 32'(bus.out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = 32'h7F7F_FFFF;
      bus.start    = (c == 2);
      bus.len      = LEN_W'(3);
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_max",   bus.out_max,        32'h3F80_0000);
      chk("hold_idx",   32'(bus.out_idx),   32'd1);
      chk("hold_nan",   32'(bus.out_nan),   32'd0);
      chk("hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    chk("after_done_busy", 32'(bus.busy), 32'd0);

    // Reset mid-scan abandons the result; first start after release accepted at once
    start_scan(4);
    send(32'h3F80_0000, 0);
    send(32'h4000_0000, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    chk("midrst_out_max",   bus.out_max,        32'd0);
    chk("midrst_out_idx",   32'(bus.out_idx),   32'd0);
    chk("midrst_out_nan",   32'(bus.out_nan),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h7F80_0000, 0, 1'b0);
    start_scan(1);
    chk("post_rst_busy", 32'(bus.busy), 32'd1);
    send(32'h7F80_0000, 0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/f_max_tracker.md
F_MAX_TRACKER -- requirements
Module: f_max_tracker

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8: width of the element count and index.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1: one-cycle pulse that begins a scan.
REQ-005 The block SHALL have port len, input, LEN_W: element count, sampled on the accepted start.
REQ-006 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 32): IEEE-754 single-precision element stream.
REQ-007 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-008 The block SHALL have ports out_max (output, 32), out_idx (output, LEN_W) and out_nan (output, 1): maximum value, its 0-based index, and a NaN-seen flag.
REQ-009 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-011 In IDLE, start=1 with len!=0 SHALL latch len, clear the element counter, have_num and out_nan, and move to SCAN.
REQ-012 start with len=0 SHALL be ignored, with the FSM remaining in IDLE.
REQ-013 start SHALL be ignored in SCAN and DONE.
REQ-014 in_ready SHALL equal 1 only in SCAN.
REQ-015 An element SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016 Each accepted non-NaN element SHALL replace the stored max and index when have_num=0 or the element compares strictly greater than the stored max; have_num SHALL then be set.
REQ-017 Ordering SHALL be full IEEE-754: sign, then exponent, then mantissa, with negative magnitudes reversed; -0 and +0 SHALL be equal; denormals SHALL be ordered by value; +/-Inf SHALL be ordered normally.
REQ-018 Ties SHALL keep the earlier index, with no update.
REQ-019 A NaN element (exp=0xFF, mantissa!=0) SHALL never update the max and SHALL set out_nan.
REQ-020 Acceptance of element number len-1 SHALL move the FSM to DONE on that edge, and out_valid SHALL be 1 on the next cycle (latency of 1 cycle after the last handshake).
REQ-021 If have_num=0 at DONE (all elements NaN), out_max SHALL be 32'h7FC00000 and out_idx SHALL be 0.
REQ-022 In DONE, out_max, out_idx and out_nan SHALL be held stable until out_ready=1.
REQ-023 The cycle in DONE with out_ready=1 SHALL return the FSM to IDLE, and out_valid SHALL drop on the next cycle.
REQ-024 The element counter SHALL NOT wrap: len up to 2^LEN_W-1 is supported, and the index of the last element is len-1.
REQ-025 in_valid gaps (stalls) SHALL pause the scan with no state change.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE and out_valid=0, in_ready=0, busy=0, out_max=0, out_idx=0, out_nan=0, and clear have_num and the counter.
REQ-027 Reset asserted mid-SCAN or mid-DONE SHALL abandon the scan without producing a result.
REQ-028 After reset release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-029 Package f_pkg SHALL hold the state enum (IDLE/SCAN/DONE), the constant F_QNAN=32'h7FC00000, and the F_EXP_MAX=8'hFF constant.
REQ-030 Sub-module f_cmp_gt SHALL be purely combinational: inputs a and b (32 bits), outputs a_gt_b and a_is_nan, implementing REQ-017 and REQ-019.
REQ-031 f_max_tracker SHALL instantiate f_cmp_gt once, with a=in_data and b=stored max.

Verification
REQ-032 The bench SHALL cover: len=4, data {1.0, -2.0, 3.5, 3.5} (3F800000, C0000000, 40600000, 40600000) -> out_max=40600000, out_idx=2, out_nan=0.
REQ-033 The bench SHALL cover: len=3, data {-1.0, -0.5, -4.0} -> out_max=BF000000, out_idx=1; plus len=2, data {+0 (00000000), -0 (80000000)} -> out_max=00000000, out_idx=0.
REQ-034 The bench SHALL cover: len=3, data {7FC00000, FF800000, 00000001} -> out_max=00000001, out_idx=2, out_nan=1; plus all-NaN len=2 -> out_max=7FC00000, out_idx=0, out_nan=1.
REQ-035 The bench SHALL cover: in_valid toggled randomly and out_ready held 0 for 5 cycles -> results unchanged, out_valid held, start during DONE ignored, and out_valid=0 the cycle after out_ready=1.
REQ-036 The bench SHALL cover: rst_n pulsed low after 2 of 4 elements -> outputs 0 immediately; the next start with len=1 and data 7F800000 -> out_max=7F800000, out_idx=0.
REQ-037 The bench SHALL cover: start with len=0 -> busy stays 0 and in_ready stays 0.
